dispatch_buffer: RTL
====================

// Module: dispatch_buffer
// PURPOSE
//  Registered, WIDTH-wide dispatch stage between Rename and the ALU/MDU/LSQ issue queues and the ROB.
//  Holds one renamed group and each cycle dispatches the longest in-order prefix that fits the free
//  slot counts. Undispatched instructions stay buffered, so partial dispatch is supported.
//  Supports flush and a stall performance counter.
// PARAMETERS
//  WIDTH   default PIPE_WIDTH      instructions per group / max dispatched per cycle
//  CNT_W   default $clog2(WIDTH+1) width of free-slot count inputs
//  PERF_W  default 32              width of stall counter
// PORTS
//  clk             in   1              clock
//  rst             in   1              synchronous, active-high reset
//  flush           in   1              discard buffered group (mispredict/exception)
//  renamed_insts   in   instruction_t[WIDTH]   group from Rename; is_valid per slot, prefix-valid
//  dispatch_rdy    out  1              buffer accepts renamed_insts this cycle
//  alu_rs_free     in   CNT_W          free ALU RS slots this cycle (saturated at WIDTH)
//  mdu_rs_free     in   CNT_W          free MDU RS slots
//  lsq_rs_free     in   CNT_W          free LSQ slots
//  rob_free        in   CNT_W          free ROB entries
//  alu_rs_we       out  WIDTH          thermometer write enables, port k = k-th ALU inst this cycle
//  mdu_rs_we       out  WIDTH          as above, MDU
//  lsq_rs_we       out  WIDTH          as above, LSQ
//  alu_rs_entries  out  instruction_t[WIDTH]  compacted, program order
//  mdu_rs_entries  out  instruction_t[WIDTH]
//  lsq_rs_entries  out  instruction_t[WIDTH]
//  rob_we          out  WIDTH          thermometer, one bit per dispatched inst
//  rob_entries     out  rob_entry_t[WIDTH]    program order
//  buf_count       out  CNT_W          valid instructions currently buffered
//  stall_cycles    out  PERF_W         cycles with buffer non-empty and zero dispatched
// BEHAVIOUR
//  - Classification: LSQ if opcode OPC_LOAD/OPC_STORE. MDU if OPC_ARI_RTYPE and funct7==FNC7_MULDIV.
//    Otherwise ALU. Only valid slots are classified.
//  - Buffer is always compacted: valid slots are 0..buf_count-1.
//  - Slot i dispatches iff the slot is valid, slots 0..i-1 all dispatch,
//    ROB-used(0..i) <= rob_free, and same-queue-used(0..i) <= that queue's free count.
//    Dispatch stops at the first slot that fails; no reordering.
//  - Outputs from dispatched slots:
//    - k-th dispatched inst drives rob_entries[k] with is_valid=1, is_ready=0, pc, rd, has_rd,
//      exception=0, opcode; all other fields '0.
//    - j-th dispatched inst of queue Q drives Q_entries[j].
//    - Entries whose we is 0 drive '0.
//  - Surviving slots shift down to slot 0 at clock edge; buf_count -= dispatched.
//  - dispatch_rdy = !rst && !flush && (all buffered slots dispatch this cycle).
//    It is combinational on the free counts and is 1 when the buffer is empty.
//  - Load: dispatch_rdy && renamed_insts[0].is_valid -> group written to buffer at edge.
//    Earliest dispatch is the next cycle (1-cycle latency). Empty group: no change.
//  - Drain and load in the same cycle is legal: old group fully leaves, new group enters.
//  - flush: all *_we = 0 that cycle; buffer cleared at edge; incoming group not accepted.
//  - stall_cycles: +1 per cycle with buf_count!=0, !flush, zero dispatched. Saturates at all-ones.
//  - Reset, including mid-group: buffer empty, buf_count=0, stall_cycles=0. All *_we=0 and
//    dispatch_rdy=0 while rst is high; buffered instructions are discarded.
//  - Free counts > WIDTH are treated as WIDTH. A count of 0 blocks every instruction for that resource.
//  - Assertion: renamed_insts is_valid is prefix-shaped; a violation is a bench error.
// TESTING  (WIDTH=2)
//  1 {ALU,ALU} loaded, all free=2 -> next cycle alu_rs_we=11, rob_we=11, buf_count 2->0, dispatch_rdy=1.
//  2 {ALU,MDU}, mdu_rs_free=0 -> alu_rs_we=01, rob_we=01, MDU shifts to slot0, buf_count=1, dispatch_rdy=0;
//    mdu_rs_free=1 next cycle -> mdu_rs_we=01, rob_entries[0].pc = MDU pc.
//  3 {LSQ,ALU}, rob_free=0 for 3 cycles -> no we, stall_cycles=3; rob_free=2 -> lsq_rs_we=01, alu_rs_we=01.
//  4 {ALU,ALU}, alu_rs_free=1 -> only slot0 goes (in-order); {LSQ,ALU} with lsq_rs_free=0 -> nothing goes.
//  5 Group buffered, flush=1 -> all we=0, dispatch_rdy=0, buf_count=0 next cycle, stall_cycles unchanged.
//  6 rst mid-group, then release -> all we=0 during rst, buf_count=0, stall_cycles=0, dispatch_rdy=1 after.

Source files
------------

// File: rtl/dispatch_buffer.sv
// Dispatch stage: buffers one renamed group and sends the longest in-order prefix that fits
// the free ALU/MDU/LSQ reservation-station slots and ROB entries each cycle.
package dispatch_buffer_pkg;
  localparam int unsigned PIPE_WIDTH = 2;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] FNC7_MULDIV   = 7'b0000001;

  typedef struct packed {
    logic        is_valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        has_rd;
    logic [31:0] imm;
  } instruction_t;

  typedef struct packed {
    logic        is_valid;
    logic        is_ready;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        has_rd;
    logic        exception;
    logic [6:0]  opcode;
    logic [31:0] result;
  } rob_entry_t;
endpackage

module dispatch_buffer
  import dispatch_buffer_pkg::*;
#(
  parameter int unsigned WIDTH  = PIPE_WIDTH,
  parameter int unsigned CNT_W  = $clog2(WIDTH + 1),
  parameter int unsigned PERF_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  instruction_t       renamed_insts [WIDTH],
  output logic               dispatch_rdy,
  input  logic [CNT_W-1:0]   alu_rs_free,
  input  logic [CNT_W-1:0]   mdu_rs_free,
  input  logic [CNT_W-1:0]   lsq_rs_free,
  input  logic [CNT_W-1:0]   rob_free,
  output logic [WIDTH-1:0]   alu_rs_we,
  output logic [WIDTH-1:0]   mdu_rs_we,
  output logic [WIDTH-1:0]   lsq_rs_we,
  output instruction_t       alu_rs_entries [WIDTH],
  output instruction_t       mdu_rs_entries [WIDTH],
  output instruction_t       lsq_rs_entries [WIDTH],
  output logic [WIDTH-1:0]   rob_we,
  output rob_entry_t         rob_entries [WIDTH],
  output logic [CNT_W-1:0]   buf_count,
  output logic [PERF_W-1:0]  stall_cycles
);
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  instruction_t        buf_q [WIDTH];
  instruction_t        buf_d [WIDTH];
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PERF_W-1:0]   stall_q, stall_d;

  int                  alu_lim, mdu_lim, lsq_lim, rob_lim;
  int                  a_n, m_n, l_n, r_n, n_disp, in_cnt;
  logic                go, is_lsq, is_mdu, fits;
  rob_entry_t          rob_tmp;

  // Free counts above WIDTH behave as WIDTH
  always_comb begin
    alu_lim = (alu_rs_free > CNT_W'(WIDTH)) ? int'(WIDTH) : int'(alu_rs_free);
    mdu_lim = (mdu_rs_free > CNT_W'(WIDTH)) ? int'(WIDTH) : int'(mdu_rs_free);
    lsq_lim = (lsq_rs_free > CNT_W'(WIDTH)) ? int'(WIDTH) : int'(lsq_rs_free);
    rob_lim = (rob_free    > CNT_W'(WIDTH)) ? int'(WIDTH) : int'(rob_free);
  end

  // In-order dispatch selection and compaction into per-queue write ports
  always_comb begin
    alu_rs_we = '0;
    mdu_rs_we = '0;
    lsq_rs_we = '0;
    rob_we    = '0;
    for (int k = 0; k < WIDTH; k++) begin
      alu_rs_entries[k] = '0;
      mdu_rs_entries[k] = '0;
      lsq_rs_entries[k] = '0;
      rob_entries[k]    = '0;
    end
    a_n     = 0;
    m_n     = 0;
    l_n     = 0;
    r_n     = 0;
    go      = !rst && !flush;
    is_lsq  = 1'b0;
    is_mdu  = 1'b0;
    fits    = 1'b0;
    rob_tmp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      is_lsq = (buf_q[i].opcode == OPC_LOAD) || (buf_q[i].opcode == OPC_STORE);
      is_mdu = (buf_q[i].opcode == OPC_ARI_RTYPE) && (buf_q[i].funct7 == FNC7_MULDIV);
      if (is_lsq)      fits = (l_n + 1) <= lsq_lim;
      else if (is_mdu) fits = (m_n + 1) <= mdu_lim;
      else             fits = (a_n + 1) <= alu_lim;
      go = go && buf_q[i].is_valid && fits && ((r_n + 1) <= rob_lim);
      if (go) begin
        if (is_lsq) begin
          lsq_rs_we[IDX_W'(l_n)]      = 1'b1;
          lsq_rs_entries[IDX_W'(l_n)] = buf_q[i];
          l_n = l_n + 1;
        end else if (is_mdu) begin
          mdu_rs_we[IDX_W'(m_n)]      = 1'b1;
          mdu_rs_entries[IDX_W'(m_n)] = buf_q[i];
          m_n = m_n + 1;
        end else begin
          alu_rs_we[IDX_W'(a_n)]      = 1'b1;
          alu_rs_entries[IDX_W'(a_n)] = buf_q[i];
          a_n = a_n + 1;
        end
        rob_tmp          = '0;
        rob_tmp.is_valid = 1'b1;
        rob_tmp.pc       = buf_q[i].pc;
        rob_tmp.rd       = buf_q[i].rd;
        rob_tmp.has_rd   = buf_q[i].has_rd;
        rob_tmp.opcode   = buf_q[i].opcode;
        rob_we[IDX_W'(r_n)]      = 1'b1;
        rob_entries[IDX_W'(r_n)] = rob_tmp;
        r_n = r_n + 1;
      end
    end
    n_disp       = r_n;
    dispatch_rdy = !rst && !flush && (n_disp == int'(count_q));
  end

  // Next buffer contents: shift survivors down, or flush, or accept a new group
  always_comb begin
    in_cnt  = 0;
    stall_d = stall_q;
    for (int i = 0; i < WIDTH; i++) begin
      buf_d[i] = '0;
      for (int j = 0; j < WIDTH; j++) begin
        if (j == i + n_disp) buf_d[i] = buf_q[j];
      end
    end
    count_d = count_q - CNT_W'(n_disp);
    if (flush) begin
      for (int i = 0; i < WIDTH; i++) buf_d[i] = '0;
      count_d = '0;
    end else if (dispatch_rdy && renamed_insts[0].is_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        buf_d[i] = renamed_insts[i].is_valid ? renamed_insts[i] : '0;
        if (renamed_insts[i].is_valid) in_cnt = in_cnt + 1;
      end
      count_d = CNT_W'(in_cnt);
    end
    if (!flush && (count_q != '0) && (n_disp == 0) && (stall_q != '1))
      stall_d = stall_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) buf_q[i] <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) buf_q[i] <= buf_d[i];
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Rename must present valid slots as a contiguous prefix
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < WIDTH; i++)
        assert (!(renamed_insts[i].is_valid && !renamed_insts[i-1].is_valid))
          else $error("dispatch_buffer: renamed_insts valid bits not prefix-shaped");
    end
  end

  assign buf_count    = count_q;
  assign stall_cycles = stall_q;
endmodule
